mem_wb_sram_stage: RTL and testbench

//  Memory stage plus MEM/WB pipeline register. Sits directly upstream of the register file.

---
 rtl/arm_defs.sv | 14 +
 rtl/sram_wait_counter.sv | 25 ++
 rtl/mem_wb_sram_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_wb_sram_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_defs.sv
// Shared definitions for the memory/write-back slice: FSM encodings and defaults.
package arm_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  localparam int unsigned ADDR_OFFSET_DEFAULT = 1024;
  localparam int REG_IDX_W = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase SRAM wait counter; phase_last marks the final cycle of a half access.
module sram_wait_counter #(
  parameter int SRAM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_last
);

  localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

  logic [CW-1:0] cnt;

  assign phase_last = en && (cnt == CW'(SRAM_WAIT - 1));

  // A finished phase restarts the count so LO and HI each get a full window.
  always_ff @(posedge clk) begin
    if (rst || !en || phase_last)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mem_wb_sram_stage.sv
// Memory stage + MEM/WB register: 32-bit loads/stores as two 16-bit SRAM halves.
// Optional one-entry last-load buffer enabled by macro LAST_LOAD_BUF_EN.
module mem_wb_sram_stage
  import arm_defs::*;
#(
  parameter int          SRAM_WAIT   = 2,
  parameter int unsigned ADDR_OFFSET = ADDR_OFFSET_DEFAULT,
  parameter int          SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic                 wb_en_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          st_val,
  output logic                 freeze,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [15:0]          sram_wdata,
  input  logic [15:0]          sram_rdata,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 wb_en_out,
  output logic [REG_IDX_W-1:0] dest_wb,
  output logic [31:0]          result_wb
);

  mem_state_t state, state_nxt;

  logic [31:0]        addr_diff;
  logic [SRAM_AW-2:0] word_idx, idx_q;
  logic [31:0]        st_q;
  logic               rd_q;
  logic [15:0]        lo_q, hi_q;
  logic               req, active, phase_last, hit;
  logic [31:0]        hit_data;
  logic               unused_addr_bits;

  assign req       = mem_r_en | mem_w_en;
  assign addr_diff = alu_result - 32'(ADDR_OFFSET);
  assign word_idx  = addr_diff[SRAM_AW:2];
  assign active    = (state == ST_LO) || (state == ST_HI);
  assign unused_addr_bits = ^{addr_diff[31:SRAM_AW+1], addr_diff[1:0]};

  sram_wait_counter #(.SRAM_WAIT(SRAM_WAIT)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .en         (active),
    .phase_last (phase_last)
  );

`ifdef LAST_LOAD_BUF_EN
  logic               buf_valid;
  logic [SRAM_AW-2:0] buf_idx;
  logic [31:0]        buf_data;

  assign hit      = mem_r_en && buf_valid && (buf_idx == word_idx);
  assign hit_data = buf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else if (state == ST_IDLE && req && !mem_r_en) begin
      buf_valid <= 1'b0;
    end else if (state == ST_HI && phase_last && rd_q) begin
      buf_valid <= 1'b1;
      buf_idx   <= idx_q;
      buf_data  <= {sram_rdata, lo_q};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          freeze    = 1'b1;
          state_nxt = hit ? ST_DONE : ST_LO;
        end
      end
      ST_LO: begin
        freeze = 1'b1;
        if (phase_last) state_nxt = ST_HI;
      end
      ST_HI: begin
        freeze = 1'b1;
        if (phase_last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operation is latched at start so the SRAM side stays stable across both halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      rd_q  <= 1'b0;
      st_q  <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        idx_q <= word_idx;
        rd_q  <= mem_r_en;
        st_q  <= st_val;
        if (hit) {hi_q, lo_q} <= hit_data;
      end
      if (state == ST_LO && phase_last && rd_q) lo_q <= sram_rdata;
      if (state == ST_HI && phase_last && rd_q) hi_q <= sram_rdata;
    end
  end

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    if (active) begin
      sram_addr = {idx_q, (state == ST_HI)};
      if (rd_q) begin
        sram_oe_n = 1'b0;
      end else begin
        sram_we_n  = 1'b0;
        sram_wdata = (state == ST_HI) ? st_q[31:16] : st_q[15:0];
      end
    end
  end

  // Frozen cycles push a bubble; destination and result keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out <= 1'b0;
      dest_wb   <= '0;
      result_wb <= '0;
    end else if (freeze) begin
      wb_en_out <= 1'b0;
    end else begin
      wb_en_out <= wb_en_in;
      dest_wb   <= dest_in;
      result_wb <= mem_r_en ? {hi_q, lo_q} : alu_result;
    end
  end

endmodule

// File: tb/tb_mem_wb_sram_stage.sv
// Directed bench for mem_wb_sram_stage with a small behavioural SRAM.
module tb_mem_wb_sram_stage;

`ifdef LAST_LOAD_BUF_EN
  localparam int HIT_FZ = 1;
  localparam int HIT_OE = 0;
`else
  localparam int HIT_FZ = 5;
  localparam int HIT_OE = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en, wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_result, st_val;
  logic        freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n, sram_oe_n;
  logic        wb_en_out;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;

  int checks = 0;
  int errors = 0;
  int nfz, noe, nwe, nwb;
  logic [17:0] a0, a1;

  logic [15:0] sram_mem [0:1023];
  logic        unused_tb_addr;

  mem_wb_sram_stage dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .wb_en_in   (wb_en_in),
    .dest_in    (dest_in),
    .alu_result (alu_result),
    .st_val     (st_val),
    .freeze     (freeze),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .wb_en_out  (wb_en_out),
    .dest_wb    (dest_wb),
    .result_wb  (result_wb)
  );

  always #5 clk = ~clk;

  assign sram_rdata     = sram_mem[sram_addr[9:0]];
  assign unused_tb_addr = ^sram_addr[17:10];

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one frozen access until freeze drops (ends sampled in DONE or IDLE).
  task automatic run_op();
    nfz = 0; noe = 0; nwe = 0; nwb = 0; a0 = '0; a1 = '0;
    #1;
    while (freeze === 1'b1 && nfz < 40) begin
      if (sram_oe_n === 1'b0) noe++;
      if (sram_we_n === 1'b0) begin
        if (nwe == 0) a0 = sram_addr;
        a1 = sram_addr;
        nwe++;
      end
      if (wb_en_out !== 1'b0) nwb++;
      nfz++;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0000;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en_in = 1'b0;
    dest_in = 4'd0; alu_result = 32'd0; st_val = 32'd0;
    tick(); tick();
    chk("rst_wb_en", {31'd0, wb_en_out}, 32'd0);
    chk("rst_dest", {28'd0, dest_wb}, 32'd0);
    chk("rst_result", result_wb, 32'd0);
    chk("rst_we_oe", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    rst = 1'b0;

    // store 0xDEADBEEF to 1028
    mem_w_en = 1'b1; alu_result = 32'd1028; st_val = 32'hDEADBEEF;
    run_op();
    chk("st_freeze", nfz, 5);
    chk("st_we_cycles", nwe, 4);
    chk("st_oe_cycles", noe, 0);
    chk("st_addr_lo", {14'd0, a0}, 32'd2);
    chk("st_addr_hi", {14'd0, a1}, 32'd3);
    tick();
    mem_w_en = 1'b0;
    chk("st_mem_lo", {16'd0, sram_mem[2]}, 32'h0000BEEF);
    chk("st_mem_hi", {16'd0, sram_mem[3]}, 32'h0000DEAD);

    // load 1028
    mem_r_en = 1'b1; wb_en_in = 1'b1; dest_in = 4'd7;
    run_op();
    chk("ld_freeze", nfz, 5);
    chk("ld_oe_cycles", noe, 4);
    chk("ld_we_cycles", nwe, 0);
    chk("ld_wb_bubble", nwb, 0);
    tick();
    chk("ld_wb_en", {31'd0, wb_en_out}, 32'd1);
    chk("ld_dest", {28'd0, dest_wb}, 32'd7);
    chk("ld_result", result_wb, 32'hDEADBEEF);
    mem_r_en = 1'b0;

    // non-memory op
    dest_in = 4'd5; alu_result = 32'h12;
    #1;
    chk("alu_freeze", {31'd0, freeze}, 32'd0);
    tick();
    chk("alu_wb_en", {31'd0, wb_en_out}, 32'd1);
    chk("alu_dest", {28'd0, dest_wb}, 32'd5);
    chk("alu_result", result_wb, 32'h12);

    // back-to-back loads with req held: 1032 then 1028
    mem_r_en = 1'b1; dest_in = 4'd9; alu_result = 32'd1032;
    run_op();
    chk("b2b1_freeze", nfz, 5);
    tick();
    chk("b2b_idle_freeze", {31'd0, freeze}, 32'd1);
    chk("b2b1_dest", {28'd0, dest_wb}, 32'd9);
    chk("b2b1_result", result_wb, 32'd0);
    dest_in = 4'd10; alu_result = 32'd1028;
    run_op();
    chk("b2b2_freeze", nfz, 5);
    tick();
    chk("b2b2_dest", {28'd0, dest_wb}, 32'd10);
    chk("b2b2_result", result_wb, 32'hDEADBEEF);
    mem_r_en = 1'b0; wb_en_in = 1'b0;

    // both enables set: read wins
    mem_r_en = 1'b1; mem_w_en = 1'b1; alu_result = 32'd1032; st_val = 32'hFFFFFFFF;
    wb_en_in = 1'b1; dest_in = 4'd3;
    run_op();
    chk("rw_we_cycles", nwe, 0);
    chk("rw_oe_cycles", noe, 4);
    tick();
    chk("rw_result", result_wb, 32'd0);
    chk("rw_mem_untouched", {16'd0, sram_mem[4]}, 32'd0);
    mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en_in = 1'b0;

    // wrap-around address, low bits ignored
    mem_w_en = 1'b1; alu_result = 32'd1; st_val = 32'h00010002;
    run_op();
    chk("wrap_addr_lo", {14'd0, a0}, 32'h3FE00);
    chk("wrap_addr_hi", {14'd0, a1}, 32'h3FE01);
    tick();
    mem_w_en = 1'b0;

    // reset in HI of a load
    mem_r_en = 1'b1; alu_result = 32'd1028; wb_en_in = 1'b1; dest_in = 4'd4;
    tick(); tick(); tick();
    chk("hi_oe_n", {31'd0, sram_oe_n}, 32'd0);
    chk("hi_addr", {14'd0, sram_addr}, 32'd3);
    rst = 1'b1; mem_r_en = 1'b0; wb_en_in = 1'b0;
    tick();
    chk("abort_freeze", {31'd0, freeze}, 32'd0);
    chk("abort_we_oe", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
    chk("abort_wb_en", {31'd0, wb_en_out}, 32'd0);
    chk("abort_addr", {14'd0, sram_addr}, 32'd0);
    rst = 1'b0;

    // load after abort starts from IDLE; repeat hits the buffer when present
    mem_r_en = 1'b1; alu_result = 32'd1028; wb_en_in = 1'b1; dest_in = 4'd2;
    run_op();
    chk("post_rst_freeze", nfz, 5);
    chk("post_rst_oe", noe, 4);
    tick();
    chk("post_rst_result", result_wb, 32'hDEADBEEF);
    run_op();
    chk("rep_freeze", nfz, HIT_FZ);
    chk("rep_oe", noe, HIT_OE);
    tick();
    chk("rep_result", result_wb, 32'hDEADBEEF);
    mem_r_en = 1'b0; mem_w_en = 1'b1; st_val = 32'hCAFEF00D;
    run_op();
    chk("st2_freeze", nfz, 5);
    tick();
    mem_w_en = 1'b0; mem_r_en = 1'b1;
    run_op();
    chk("inval_freeze", nfz, 5);
    chk("inval_oe", noe, 4);
    tick();
    chk("inval_result", result_wb, 32'hCAFEF00D);
    mem_r_en = 1'b0; wb_en_in = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
